// File: rtl/tff_counter_if.sv
// Control and status bundle for the T flip-flop counter bank.
// The master drives mode/load/clear controls; the slave (counter) returns state and flags.
interface tff_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t_vec;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, t_vec, load, load_val, clr_ovf,
        input  q, q_bar, tc, ovf
    );

    modport slave (
        input  en, mode, t_vec, load, load_val, clr_ovf,
        output q, q_bar, tc, ovf
    );
endinterface

// File: rtl/tff_counter.sv
// WIDTH-bit bank of T flip-flops: up/down ripple-style count, raw toggle mask or hold,
// with synchronous load, optional saturation, a registered terminal-count pulse and sticky overflow.
module tff_counter #(
    parameter int               WIDTH     = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    tff_counter_if.slave   bus
);
    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_TGL = 2'b10;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_dn;
    logic             w_bnd_up;
    logic             w_bnd_dn;

    // Each bit toggles when every lower bit is 1 (up) or 0 (down).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tinput
            if (gi == 0) begin : g_lsb
                assign w_t_up[gi] = 1'b1;
                assign w_t_dn[gi] = 1'b1;
            end else begin : g_upper
                assign w_t_up[gi] = &r_q[gi-1:0];
                assign w_t_dn[gi] = &(~r_q[gi-1:0]);
            end
        end
    endgenerate

    assign w_bnd_up = &r_q;
    assign w_bnd_dn = ~|r_q;

    always_comb begin
        w_q_next   = r_q;
        w_tc_next  = 1'b0;
        w_ovf_next = r_ovf & ~bus.clr_ovf;
        if (bus.load) begin
            w_q_next = bus.load_val;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_UP: begin
                    if (!(w_bnd_up && SATURATE)) w_q_next = r_q ^ w_t_up;
                    if (w_bnd_up) begin
                        w_tc_next  = 1'b1;
                        w_ovf_next = 1'b1;
                    end
                end
                MODE_DN: begin
                    if (!(w_bnd_dn && SATURATE)) w_q_next = r_q ^ w_t_dn;
                    if (w_bnd_dn) begin
                        w_tc_next  = 1'b1;
                        w_ovf_next = 1'b1;
                    end
                end
                MODE_TGL: w_q_next = r_q ^ bus.t_vec;
                default:  w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RESET_VAL;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_tc  <= w_tc_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign bus.q     = r_q;
    assign bus.q_bar = ~r_q;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
endmodule
